// File: rtl/reg_write_bank_if.sv
// Write-port bundle for reg_write_bank.
//   master : requester side, drives write/clear requests, observes busy/wr_ack
//   slave  : register bank side
//   wr_en/wr_addr/wr_data/wr_mode : one write request per cycle
//   clr_start                     : request a 16-cycle bulk clear
//   busy                          : clear sequence in progress
//   wr_ack                        : one-cycle pulse after a committed write
interface reg_write_bank_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       wr_mode;
  logic             clr_start;
  logic             busy;
  logic             wr_ack;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mode, clr_start,
    input  busy, wr_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mode, clr_start,
    output busy, wr_ack
  );
endinterface

// File: rtl/reg_write_bank.sv
// Write side of the 16x16 register file.
//   clk, reset : clock, synchronous active-high reset
//   bus        : write/clear request bundle (slave side)
//   r0..r15    : register contents, wired straight to the read mux
// Writes: wr_mode 00 full word, 01 low byte, 10 load-upper
// ({wr_data[low], zeros}), 11 no-op. A clear walks r0..r15 one per cycle
// with busy high; writes arriving while busy are dropped without ack.
module reg_write_bank #(
  parameter int               WIDTH   = 16,
  parameter int               NREGS   = 16,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  reg_write_bank_if.slave  bus,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15
);
  localparam int HALF = WIDTH / 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [0:0]                  state;
  logic [3:0]                  cnt;
  logic                        ack_q;
  logic                        wr_commit;
  logic [WIDTH-1:0]            wr_val;

  // Writes only land in IDLE; the reserved mode is a silent no-op.
  assign wr_commit = bus.wr_en && (state == IDLE) && (bus.wr_mode != 2'b11);

  always_comb begin
    wr_val = bus.wr_data;
    case (bus.wr_mode)
      2'b01:   wr_val = {regs[bus.wr_addr][WIDTH-1:HALF], bus.wr_data[HALF-1:0]};
      2'b10:   wr_val = {bus.wr_data[HALF-1:0], {HALF{1'b0}}};
      default: wr_val = bus.wr_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs  <= {NREGS{CLR_VAL}};
      state <= IDLE;
      cnt   <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= wr_commit;
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          // clr_start is ignored here; counter wraps 15->0 on exit.
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= IDLE;
        end
      endcase
      // Write and clear never overlap: commits only happen in IDLE. A write
      // accepted on the clear-start edge is simply overwritten later.
      if (wr_commit)        regs[bus.wr_addr] <= wr_val;
      if (state == CLEAR)   regs[cnt]         <= CLR_VAL;
    end
  end

  assign bus.busy   = (state == CLEAR);
  assign bus.wr_ack = ack_q;

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];
endmodule

// File: tb/tb_reg_write_bank.sv
module tb_reg_write_bank;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] r [16];
  logic [15:0] exp_r [16];
  int n_chk = 0;
  int n_ok  = 0;
  int acks;
  int busy_cyc;

  always #5 clk = ~clk;

  reg_write_bank_if #(.WIDTH(16)) bus ();

  reg_write_bank #(.WIDTH(16), .NREGS(16), .CLR_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),
    .r4(r[4]),   .r5(r[5]),   .r6(r[6]),   .r7(r[7]),
    .r8(r[8]),   .r9(r[9]),   .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_mode = 2'b00; bus.clr_start = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_mode = m;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_r%0d", tag, i), 32'(r[i]), 32'(exp_r[i]));
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_r[i] = 16'h0000;
    check_all("rst");
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.wr_ack), 0);

    // Full-word write to every address; each lands the cycle after.
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 16'h1000 + 16'(i), 2'b00);
      if (bus.wr_ack) acks++;
      check($sformatf("fw_r%0d", i), 32'(r[i]), 32'(16'h1000 + 16'(i)));
      if (i < 15) check($sformatf("fw_next%0d", i + 1), 32'(r[i+1]), 0);
    end
    tick();
    check("fw_ack_lo", 32'(bus.wr_ack), 0);
    check("fw_acks", 32'(acks), 16);
    for (int i = 0; i < 16; i++) exp_r[i] = 16'h1000 + 16'(i);
    check_all("fw");

    // Byte and load-upper modes.
    wr(4'd5, 16'hABCD, 2'b00);
    check("r5_full", 32'(r[5]), 32'h0000ABCD);
    wr(4'd5, 16'h1234, 2'b01);
    check("r5_lowb", 32'(r[5]), 32'h0000AB34);
    check("r5_lowb_ack", 32'(bus.wr_ack), 1);
    wr(4'd5, 16'h00F7, 2'b10);
    check("r5_lui", 32'(r[5]), 32'h0000F700);
    check("r4_keep", 32'(r[4]), 32'h00001004);

    // Reserved mode is a no-op without ack.
    wr(4'd3, 16'h5555, 2'b00);
    wr(4'd3, 16'h0000, 2'b11);
    check("r3_nop", 32'(r[3]), 32'h00005555);
    check("nop_ack", 32'(bus.wr_ack), 0);
    exp_r[3] = 16'h5555; exp_r[5] = 16'hF700;

    // Bulk clear; r7 write mid-clear is dropped, clr_start mid-clear ignored.
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    busy_cyc = 0;
    check("clr_busy0", 32'(bus.busy), 1);
    check("clr_r0_held", 32'(r[0]), 32'h00001000);
    for (int k = 0; k < 20 && bus.busy; k++) begin
      busy_cyc++;
      bus.wr_en = (k == 6);
      bus.wr_addr = 4'd7; bus.wr_data = 16'h7777; bus.wr_mode = 2'b00;
      bus.clr_start = (k == 10);
      tick();
      if (k < 16) exp_r[k] = 16'h0000;
      check_all($sformatf("clr%0d", k));
      check($sformatf("clr_ack%0d", k), 32'(bus.wr_ack), 0);
    end
    idle_in();
    check("clr_busy_cycles", 32'(busy_cyc), 16);
    check("clr_done_busy", 32'(bus.busy), 0);
    tick();
    check("clr_no_restart", 32'(bus.busy), 0);

    // clr_start together with a write to r9.
    bus.clr_start = 1'b1;
    wr(4'd9, 16'h9999, 2'b00);
    bus.clr_start = 1'b0;
    check("cw_ack", 32'(bus.wr_ack), 1);
    check("cw_r9", 32'(r[9]), 32'h00009999);
    check("cw_busy", 32'(bus.busy), 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 8) check("cw_r9_before", 32'(r[9]), 32'h00009999);
      if (k == 9) check("cw_r9_after", 32'(r[9]), 0);
    end
    check("cw_busy_end", 32'(bus.busy), 0);

    // Reset in the 6th cycle of a clear.
    wr(4'd15, 16'hFFFF, 2'b00);
    wr(4'd14, 16'hEEEE, 2'b00);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("rc_busy_pre", 32'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_r[i] = 16'h0000;
    check("rc_busy", 32'(bus.busy), 0);
    check("rc_ack", 32'(bus.wr_ack), 0);
    check_all("rc");
    wr(4'd2, 16'h0042, 2'b00);
    check("rc_r2", 32'(r[2]), 32'h00000042);
    check("rc_r2_ack", 32'(bus.wr_ack), 1);
    check("rc_idle", 32'(bus.busy), 0);
    tick();
    check("rc_r3", 32'(r[3]), 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
